// File: rtl/dec_trigger_cnt_pkg.sv
// Shared types and constants for the decode-stage instruction-address trigger unit.
//
// Contents:
//   trig_cfg_t       per-trigger configuration as delivered by the TLU trigger CSRs
//   TRIG_MODE_*      compare-mode encodings for trig_cfg_t.mode
//   trig_enabled()   whether a trigger may match instruction fetches in the current mode
package dec_trigger_cnt_pkg;

    typedef struct packed {
        logic        select;   // 1: data-address trigger, never matches a PC
        logic        execute;  // trigger on instruction execution
        logic        m;        // active in machine mode
        logic        chain;    // even trigger only: AND with the next odd trigger
        logic [1:0]  mode;     // TRIG_MODE_*
        logic [31:0] tdata2;   // compare value / NAPOT mask
    } trig_cfg_t;

    localparam logic [1:0] TRIG_MODE_EQ    = 2'd0;
    localparam logic [1:0] TRIG_MODE_NAPOT = 2'd1;
    localparam logic [1:0] TRIG_MODE_GE    = 2'd2;
    localparam logic [1:0] TRIG_MODE_LT    = 2'd3;

    function automatic logic trig_enabled(trig_cfg_t cfg);
        return cfg.execute & ~cfg.select & cfg.m;
    endfunction

endpackage

// File: rtl/dec_trigger_cnt_if.sv
// Bundle of the trigger-unit signals shared between decode/TLU and dec_trigger_cnt.
//
// master (decode/TLU side): drives configuration, lane PCs/valids, stall and CSR writes;
//                           receives hit-count readback and per-lane match vectors.
// slave  (trigger unit)   : the reverse.
interface dec_trigger_cnt_if #(
    parameter int unsigned NUM_TRIG  = 4,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned CNT_W     = 8
);
    import dec_trigger_cnt_pkg::*;

    trig_cfg_t [NUM_TRIG-1:0]               trigger_pkt_any;
    logic      [NUM_LANES-1:0][30:0]        dec_pc_d;
    logic      [NUM_LANES-1:0]              dec_valid_d;
    logic                                   dec_stall_d;
    logic      [NUM_TRIG-1:0]               trig_cnt_wr;
    logic      [CNT_W-1:0]                  trig_cnt_wdata;
    logic      [NUM_TRIG-1:0][CNT_W-1:0]    trig_cnt_rdata;
    logic      [NUM_LANES-1:0][NUM_TRIG-1:0] dec_trigger_match_d;

    modport master (
        output trigger_pkt_any, dec_pc_d, dec_valid_d, dec_stall_d,
        output trig_cnt_wr, trig_cnt_wdata,
        input  trig_cnt_rdata, dec_trigger_match_d
    );

    modport slave (
        input  trigger_pkt_any, dec_pc_d, dec_valid_d, dec_stall_d,
        input  trig_cnt_wr, trig_cnt_wdata,
        output trig_cnt_rdata, dec_trigger_match_d
    );

endinterface

// File: rtl/dec_trig_cmp.sv
// Mode-selecting PC comparator for one trigger on one decode lane.
//
// Ports:
//   mode    in   2   compare mode (TRIG_MODE_*)
//   tdata2  in   32  trigger compare value
//   pc      in   31  lane PC[31:1]
//   match   out  1   compare result (enables are applied by the caller)
//
// The compare address borrows bit 0 from tdata2 so that halfword PCs compare cleanly.
module dec_trig_cmp
    import dec_trigger_cnt_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [31:0] tdata2,
    input  logic [30:0] pc,
    output logic        match
);

    logic [31:0] addr;
    logic        napot_match;

    assign addr = {pc, tdata2[0]};

    rvmaskandmatch #(
        .WIDTH (32)
    ) u_napot (
        .mask   (tdata2),
        .data   (addr),
        .masken (1'b1),
        .match  (napot_match)
    );

    always_comb begin
        match = 1'b0;
        case (mode)
            TRIG_MODE_EQ:    match = (addr == tdata2);
            TRIG_MODE_NAPOT: match = napot_match;
            TRIG_MODE_GE:    match = (addr >= tdata2);
            TRIG_MODE_LT:    match = (addr < tdata2);
            default:         match = 1'b0;
        endcase
    end

endmodule

// File: rtl/rvmaskandmatch.sv
// Masked (NAPOT) address compare.
//
// Ports:
//   mask    in   WIDTH  compare value; trailing ones select the don't-care low bits
//   data    in   WIDTH  address under test
//   masken  in   1      enable the trailing-ones masking
//   match   out  1      data lies inside the region described by mask
//
// With masking enabled, every bit up to and including the first zero of mask is ignored.
// An all-ones mask is treated as an exact compare rather than "match everything".
module rvmaskandmatch #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] data,
    input  logic             masken,
    output logic             match
);

    logic [WIDTH-1:0] matchvec;
    logic             masken_or_fullmask;

    assign masken_or_fullmask = masken & ~(&mask);
    assign matchvec[0]        = masken_or_fullmask | (mask[0] == data[0]);

    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        // Bit i is don't-care when all lower mask bits are ones.
        assign matchvec[i] = (masken_or_fullmask & (&mask[i-1:0])) | (mask[i] == data[i]);
    end

    assign match = &matchvec;

endmodule

// File: rtl/dec_trigger_cnt.sv
// Decode-stage instruction-address trigger unit with per-trigger hit counting and
// even/odd trigger chaining.
//
// Ports:
//   clk   in   core clock
//   rst   in   synchronous, active-high reset (clears all hit counts)
//   bus   slave modport of dec_trigger_cnt_if:
//           trigger_pkt_any, dec_pc_d, dec_valid_d, dec_stall_d, trig_cnt_wr, trig_cnt_wdata in;
//           trig_cnt_rdata (hit counts), dec_trigger_match_d (per-lane fire vector) out
//
// Each trigger holds a hit count. A count of 0 or 1 fires on every hit; N>1 swallows
// N-1 qualifying hits and fires on the Nth, after which the count sits at 0. Lanes are
// evaluated oldest first within a cycle so several hits in one cycle consume the count
// in program order. A chained pair uses the even trigger's count; the odd count is held.
module dec_trigger_cnt
    import dec_trigger_cnt_pkg::*;
#(
    parameter int unsigned NUM_TRIG  = 4,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned CNT_W     = 8
) (
    input logic            clk,
    input logic            rst,
    dec_trigger_cnt_if.slave bus
);

    localparam int unsigned NUM_PAIRS = NUM_TRIG / 2;

    typedef struct packed {
        logic [NUM_LANES-1:0] fire;
        logic [CNT_W-1:0]     cnt;
    } eval_t;

    // Walk the lanes oldest first with a running count. A stalled cycle can still fire
    // but never moves the count.
    function automatic eval_t eval_lanes(logic [CNT_W-1:0]     cnt,
                                         logic [NUM_LANES-1:0] hit,
                                         logic [NUM_LANES-1:0] valid,
                                         logic                 stall);
        eval_t            r;
        logic [CNT_W-1:0] c;
        c      = cnt;
        r.fire = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (hit[l] && valid[l]) begin
                r.fire[l] = (c <= CNT_W'(1));
                if (!stall) begin
                    c = (c <= CNT_W'(1)) ? '0 : c - CNT_W'(1);
                end
            end
        end
        r.cnt = c;
        return r;
    endfunction

    logic                 cmp     [NUM_LANES][NUM_TRIG];
    logic [NUM_LANES-1:0] fire_lo [NUM_PAIRS];
    logic [NUM_LANES-1:0] fire_hi [NUM_PAIRS];
    logic [CNT_W-1:0]     cnt_lo  [NUM_PAIRS];
    logic [CNT_W-1:0]     cnt_hi  [NUM_PAIRS];
    logic [NUM_PAIRS-1:0] odd_chain;
    logic                 unused_odd_chain;

    // Comparator array: one per lane per trigger.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar t = 0; t < NUM_TRIG; t++) begin : g_trig
            dec_trig_cmp u_cmp (
                .mode   (bus.trigger_pkt_any[t].mode),
                .tdata2 (bus.trigger_pkt_any[t].tdata2),
                .pc     (bus.dec_pc_d[l]),
                .match  (cmp[l][t])
            );
        end
    end

    // Hit counting and chaining, one block per even/odd trigger pair.
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        localparam int unsigned E = 2 * p;
        localparam int unsigned O = 2 * p + 1;

        logic                 chain;
        logic                 en_e;
        logic                 en_o;
        logic [NUM_LANES-1:0] hit_e;
        logic [NUM_LANES-1:0] hit_o;
        eval_t                ev_e;
        eval_t                ev_o;
        logic [CNT_W-1:0]     cnt_e_q, cnt_e_d;
        logic [CNT_W-1:0]     cnt_o_q, cnt_o_d;

        assign chain        = bus.trigger_pkt_any[E].chain;
        assign en_e         = trig_enabled(bus.trigger_pkt_any[E]);
        assign en_o         = trig_enabled(bus.trigger_pkt_any[O]);
        assign odd_chain[p] = bus.trigger_pkt_any[O].chain;

        always_comb begin
            hit_e = '0;
            hit_o = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (chain) begin
                    hit_e[l] = en_e & cmp[l][E] & en_o & cmp[l][O];
                end else begin
                    hit_e[l] = en_e & cmp[l][E];
                    hit_o[l] = en_o & cmp[l][O];
                end
            end
        end

        // With chaining hit_o is all zero, so the odd count simply holds.
        assign ev_e = eval_lanes(cnt_e_q, hit_e, bus.dec_valid_d, bus.dec_stall_d);
        assign ev_o = eval_lanes(cnt_o_q, hit_o, bus.dec_valid_d, bus.dec_stall_d);

        // A CSR write overrides whatever the hits would have done this cycle.
        assign cnt_e_d = bus.trig_cnt_wr[E] ? bus.trig_cnt_wdata : ev_e.cnt;
        assign cnt_o_d = bus.trig_cnt_wr[O] ? bus.trig_cnt_wdata : ev_o.cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_e_q <= '0;
                cnt_o_q <= '0;
            end else begin
                cnt_e_q <= cnt_e_d;
                cnt_o_q <= cnt_o_d;
            end
        end

        assign fire_lo[p] = ev_e.fire;
        assign fire_hi[p] = chain ? ev_e.fire : ev_o.fire;
        assign cnt_lo[p]  = cnt_e_q;
        assign cnt_hi[p]  = cnt_o_q;
    end

    // The chain bit of an odd trigger has no function.
    assign unused_odd_chain = ^odd_chain;

    always_comb begin
        bus.dec_trigger_match_d = '0;
        bus.trig_cnt_rdata      = '0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                bus.dec_trigger_match_d[l][2*p]   = fire_lo[p][l];
                bus.dec_trigger_match_d[l][2*p+1] = fire_hi[p][l];
            end
            bus.trig_cnt_rdata[2*p]   = cnt_lo[p];
            bus.trig_cnt_rdata[2*p+1] = cnt_hi[p];
        end
    end

endmodule

// File: tb/tb_dec_trigger_cnt.sv
// Self-checking bench for dec_trigger_cnt: directed scenarios followed by a randomized
// run against a behavioural model of the hit-count rules.
module tb_dec_trigger_cnt;
    import dec_trigger_cnt_pkg::*;

    localparam int unsigned NT = 4;
    localparam int unsigned NL = 2;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dec_trigger_cnt_if #(.NUM_TRIG(NT), .NUM_LANES(NL), .CNT_W(CW)) bus ();

    dec_trigger_cnt #(.NUM_TRIG(NT), .NUM_LANES(NL), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned             m_cnt  [NT];
    int unsigned             m_next [NT];
    logic [NL-1:0][NT-1:0]   exp_match;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    function automatic trig_cfg_t mk_cfg(logic [1:0] mode, logic [31:0] td, logic chain);
        trig_cfg_t c;
        c.select  = 1'b0;
        c.execute = 1'b1;
        c.m       = 1'b1;
        c.chain   = chain;
        c.mode    = mode;
        c.tdata2  = td;
        return c;
    endfunction

    task automatic clear_inputs();
        bus.trigger_pkt_any = '0;
        bus.dec_pc_d        = '0;
        bus.dec_valid_d     = '0;
        bus.dec_stall_d     = 1'b0;
        bus.trig_cnt_wr     = '0;
        bus.trig_cnt_wdata  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < NT; t++) m_cnt[t] = 0;
    endtask

    task automatic write_cnt(int idx, int val);
        bus.trig_cnt_wr    = NT'(1) << idx;
        bus.trig_cnt_wdata = CW'(val);
        @(negedge clk);
        bus.trig_cnt_wr    = '0;
        bus.trig_cnt_wdata = '0;
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_cmp(trig_cfg_t c, logic [30:0] pc);
        logic [31:0] a;
        int          t;
        a = {pc, c.tdata2[0]};
        case (c.mode)
            TRIG_MODE_EQ: return a == c.tdata2;
            TRIG_MODE_GE: return a >= c.tdata2;
            TRIG_MODE_LT: return a < c.tdata2;
            default: begin
                t = 0;
                while (t < 32 && c.tdata2[t]) t++;
                if (t == 32) return a == c.tdata2;
                return (64'(a) >> (t + 1)) == (64'(c.tdata2) >> (t + 1));
            end
        endcase
    endfunction

    function automatic bit model_raw(trig_cfg_t c, logic [30:0] pc);
        return c.execute && !c.select && c.m && model_cmp(c, pc);
    endfunction

    // A lane fires when the count is within reach of the qualifying hits seen so far in
    // older lanes; the count drops by the number of qualifying hits, floored at zero.
    task automatic group_eval(input int unsigned cnt, input logic [NL-1:0] hit,
                              output logic [NL-1:0] fire, output int unsigned next);
        int unsigned q;
        q    = 0;
        fire = '0;
        for (int l = 0; l < NL; l++) begin
            if (hit[l] && bus.dec_valid_d[l]) begin
                fire[l] = (cnt <= q + 1);
                if (!bus.dec_stall_d) q++;
            end
        end
        next = (cnt > q) ? cnt - q : 0;
    endtask

    task automatic model_cycle();
        logic [NL-1:0] raw [NT];
        for (int t = 0; t < NT; t++)
            for (int l = 0; l < NL; l++)
                raw[t][l] = model_raw(bus.trigger_pkt_any[t], bus.dec_pc_d[l]);
        exp_match = '0;
        for (int e = 0; e < NT; e += 2) begin
            logic [NL-1:0] f_e, f_o;
            int unsigned   n_e, n_o;
            if (bus.trigger_pkt_any[e].chain) begin
                group_eval(m_cnt[e], raw[e] & raw[e+1], f_e, n_e);
                f_o = f_e;
                n_o = m_cnt[e+1];
            end else begin
                group_eval(m_cnt[e], raw[e], f_e, n_e);
                group_eval(m_cnt[e+1], raw[e+1], f_o, n_o);
            end
            for (int l = 0; l < NL; l++) begin
                exp_match[l][e]   = f_e[l];
                exp_match[l][e+1] = f_o[l];
            end
            m_next[e]   = bus.trig_cnt_wr[e]   ? int'(bus.trig_cnt_wdata) : n_e;
            m_next[e+1] = bus.trig_cnt_wr[e+1] ? int'(bus.trig_cnt_wdata) : n_o;
        end
        if (rst) for (int t = 0; t < NT; t++) m_next[t] = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.trigger_pkt_any[0] = mk_cfg(TRIG_MODE_EQ, 32'h0000_0400, 1'b0);
        bus.dec_pc_d[0]        = 31'h200;
        bus.dec_valid_d        = 2'b01;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.trig_cnt_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata_during: got %h, want 0", bus.trig_cnt_rdata);
        end
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_match_during: got %h, want 01", bus.dec_trigger_match_d);
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.trig_cnt_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata_after: got %h, want 0", bus.trig_cnt_rdata);
        end
        write_cnt(2, 9);
        n_checks++;
        if (bus.trig_cnt_rdata[2] !== 8'd9) begin
            n_fail++;
            $display("FAIL csr_write: got %0d, want 9", bus.trig_cnt_rdata[2]);
        end
    endtask

    task automatic test_eq();
        do_reset();
        bus.trigger_pkt_any[0] = mk_cfg(TRIG_MODE_EQ, 32'h8000_0100, 1'b0);
        bus.dec_pc_d[0]        = 31'h4000_0080;
        bus.dec_pc_d[1]        = 31'h4000_0080;
        bus.dec_valid_d        = 2'b01;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h01) begin
            n_fail++;
            $display("FAIL eq_hit: got %h, want 01", bus.dec_trigger_match_d);
        end
        @(negedge clk);
        n_checks++;
        if (bus.trig_cnt_rdata[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL eq_cnt: got %0d, want 0", bus.trig_cnt_rdata[0]);
        end
        bus.dec_pc_d[0] = 31'h4000_0082;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h00) begin
            n_fail++;
            $display("FAIL eq_miss: got %h, want 00", bus.dec_trigger_match_d);
        end
        @(negedge clk);
    endtask

    task automatic test_napot_count();
        do_reset();
        write_cnt(1, 3);
        bus.trigger_pkt_any[1] = mk_cfg(TRIG_MODE_NAPOT, 32'h0000_10FF, 1'b0);
        bus.dec_pc_d[0]        = 31'h800;
        bus.dec_valid_d        = 2'b01;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.trig_cnt_rdata[1] !== CW'(3 - k)) begin
                n_fail++;
                $display("FAIL napot_rdata k=%0d: got %0d, want %0d", k,
                         bus.trig_cnt_rdata[1], 3 - k);
            end
            #1;
            n_checks++;
            if (bus.dec_trigger_match_d[0][1] !== (k == 2)) begin
                n_fail++;
                $display("FAIL napot_fire k=%0d: got %b, want %b", k,
                         bus.dec_trigger_match_d[0][1], (k == 2));
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.trig_cnt_rdata[1] !== 8'd0) begin
            n_fail++;
            $display("FAIL napot_rdata_after: got %0d, want 0", bus.trig_cnt_rdata[1]);
        end
        bus.dec_pc_d[0] = 31'h900;  // 0x1200: outside the 512-byte region
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h00) begin
            n_fail++;
            $display("FAIL napot_outside: got %h, want 00", bus.dec_trigger_match_d);
        end
        bus.dec_pc_d[0] = 31'h8FF;  // 0x11FE: last halfword inside
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h02) begin
            n_fail++;
            $display("FAIL napot_edge: got %h, want 02", bus.dec_trigger_match_d);
        end
        @(negedge clk);
    endtask

    task automatic test_multi_lane();
        do_reset();
        write_cnt(2, 2);
        bus.trigger_pkt_any[2] = mk_cfg(TRIG_MODE_GE, 32'h0000_1000, 1'b0);
        bus.dec_pc_d[0]        = 31'h800;
        bus.dec_pc_d[1]        = 31'h802;
        bus.dec_valid_d        = 2'b11;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h40) begin
            n_fail++;
            $display("FAIL multi_lane_fire: got %h, want 40", bus.dec_trigger_match_d);
        end
        @(negedge clk);
        n_checks++;
        if (bus.trig_cnt_rdata[2] !== 8'd0) begin
            n_fail++;
            $display("FAIL multi_lane_cnt: got %0d, want 0", bus.trig_cnt_rdata[2]);
        end
    endtask

    task automatic test_chain();
        do_reset();
        write_cnt(1, 5);
        bus.trigger_pkt_any[0] = mk_cfg(TRIG_MODE_GE, 32'h0000_2000, 1'b1);
        bus.trigger_pkt_any[1] = mk_cfg(TRIG_MODE_LT, 32'h0000_3000, 1'b0);
        bus.dec_pc_d[0]        = 31'h1400;
        bus.dec_pc_d[1]        = 31'h1C00;
        bus.dec_valid_d        = 2'b11;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h03) begin
            n_fail++;
            $display("FAIL chain_match: got %h, want 03", bus.dec_trigger_match_d);
        end
        @(negedge clk);
        n_checks++;
        if (bus.trig_cnt_rdata[1] !== 8'd5 || bus.trig_cnt_rdata[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL chain_cnt_hold: got %0d/%0d, want 0/5",
                     bus.trig_cnt_rdata[0], bus.trig_cnt_rdata[1]);
        end
    endtask

    task automatic test_stall_write();
        do_reset();
        write_cnt(3, 4);
        bus.trigger_pkt_any[3] = mk_cfg(TRIG_MODE_EQ, 32'h0000_5000, 1'b0);
        bus.dec_pc_d[0]        = 31'h2800;
        bus.dec_valid_d        = 2'b01;
        bus.dec_stall_d        = 1'b1;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h00) begin
            n_fail++;
            $display("FAIL stall_nofire: got %h, want 00", bus.dec_trigger_match_d);
        end
        @(negedge clk);
        n_checks++;
        if (bus.trig_cnt_rdata[3] !== 8'd4) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d, want 4", bus.trig_cnt_rdata[3]);
        end
        bus.dec_stall_d    = 1'b0;
        bus.trig_cnt_wr    = 4'b1000;
        bus.trig_cnt_wdata = 8'd7;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h00) begin
            n_fail++;
            $display("FAIL write_hit_old_cnt: got %h, want 00", bus.dec_trigger_match_d);
        end
        @(negedge clk);
        bus.trig_cnt_wr = '0;
        n_checks++;
        if (bus.trig_cnt_rdata[3] !== 8'd7) begin
            n_fail++;
            $display("FAIL write_wins: got %0d, want 7", bus.trig_cnt_rdata[3]);
        end
        bus.dec_valid_d = 2'b00;
        write_cnt(3, 1);
        bus.dec_valid_d = 2'b01;
        bus.dec_stall_d = 1'b1;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h08) begin
            n_fail++;
            $display("FAIL stall_fire: got %h, want 08", bus.dec_trigger_match_d);
        end
        @(negedge clk);
        n_checks++;
        if (bus.trig_cnt_rdata[3] !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_fire_hold: got %0d, want 1", bus.trig_cnt_rdata[3]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_cnt(0, 5);
        bus.trigger_pkt_any[0] = mk_cfg(TRIG_MODE_EQ, 32'h0000_6000, 1'b0);
        bus.dec_pc_d[0]        = 31'h3000;
        bus.dec_valid_d        = 2'b01;
        @(negedge clk);
        n_checks++;
        if (bus.trig_cnt_rdata[0] !== 8'd4) begin
            n_fail++;
            $display("FAIL mid_count: got %0d, want 4", bus.trig_cnt_rdata[0]);
        end
        bus.dec_valid_d = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.trig_cnt_rdata !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %h, want 0", bus.trig_cnt_rdata);
        end
        bus.dec_valid_d = 2'b01;
        #1;
        n_checks++;
        if (bus.dec_trigger_match_d !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_reset_refire: got %h, want 01", bus.dec_trigger_match_d);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] base;
        base = 32'h4000_0000;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 25 == 0) begin
                for (int t = 0; t < NT; t++) begin
                    trig_cfg_t c;
                    c.mode    = 2'($urandom_range(0, 3));
                    c.chain   = 1'($urandom_range(0, 1));
                    c.execute = ($urandom_range(0, 7) != 0);
                    c.select  = ($urandom_range(0, 7) == 0);
                    c.m       = ($urandom_range(0, 7) != 0);
                    c.tdata2  = base + $urandom_range(0, 511);
                    if (c.mode == TRIG_MODE_NAPOT)
                        c.tdata2 = c.tdata2 | ((32'd1 << $urandom_range(0, 6)) - 32'd1);
                    bus.trigger_pkt_any[t] = c;
                end
            end
            for (int l = 0; l < NL; l++)
                bus.dec_pc_d[l] = 31'((base + $urandom_range(0, 511)) >> 1);
            bus.dec_valid_d    = NL'($urandom_range(0, 3));
            bus.dec_stall_d    = ($urandom_range(0, 3) == 0);
            bus.trig_cnt_wr    = ($urandom_range(0, 5) == 0) ?
                                 NT'(1) << $urandom_range(0, NT - 1) : '0;
            bus.trig_cnt_wdata = CW'($urandom_range(0, 6));
            rst                = ($urandom_range(0, 60) == 0);
            #1;
            model_cycle();
            n_checks++;
            if (bus.dec_trigger_match_d !== exp_match) begin
                n_fail++;
                $display("FAIL rand_match cyc=%0d: got %h, want %h", cyc,
                         bus.dec_trigger_match_d, exp_match);
            end
            for (int t = 0; t < NT; t++) begin
                n_checks++;
                if (bus.trig_cnt_rdata[t] !== CW'(m_cnt[t])) begin
                    n_fail++;
                    $display("FAIL rand_cnt cyc=%0d t=%0d: got %0d, want %0d", cyc, t,
                             bus.trig_cnt_rdata[t], m_cnt[t]);
                end
            end
            @(negedge clk);
            for (int t = 0; t < NT; t++) m_cnt[t] = m_next[t];
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_eq();
        test_napot_count();
        test_multi_lane();
        test_chain();
        test_stall_write();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
